nav_input_conditioner: RTL and testbench

- Front-end conditioner for menu/gameplay navigation. Sits directly upstream of the menu state machine's btn_up/btn_down/btn_left/btn_right inputs.
- Merges raw push-button and PS/2 hold levels per direction, then synchronises and debounces them.
- Emits single-cycle press pulses with optional hold-to-repeat. At most one direction pulses per cycle, under fixed-priority arbitration.

---
 rtl/nav_input_conditioner.sv | 188 ++++++++++++++++++
 tb/tb_nav_input_conditioner.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/nav_input_conditioner.sv
// nav_input_conditioner: merges board keys and keyboard hold levels per
// direction, synchronises and debounces them, and emits one-cycle press /
// hold-to-repeat pulses with fixed priority up > down > left > right.
// Ports:
//   clk        system clock
//   resetn     synchronous active-low reset
//   key_n      raw board keys, active-low, [0]=right [1]=up [2]=down [3]=left
//   kb_hold    raw keyboard hold levels, active-high, same ordering
//   repeat_en  1 = hold-to-repeat enabled, 0 = single pulse per press
//   btn_up/btn_down/btn_left/btn_right  registered one-cycle pulses
//   held       debounced pressed level per channel, key_n ordering
module nav_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] key_n,
  input  logic [3:0] kb_hold,
  input  logic       repeat_en,
  output logic       btn_up,
  output logic       btn_down,
  output logic       btn_left,
  output logic       btn_right,
  output logic [3:0] held
);

  localparam int unsigned NCH = 4;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [NCH-1:0]   key_s1, key_s2;
  logic [NCH-1:0]   kb_s1, kb_s2;
  logic [NCH-1:0]   raw_c;
  logic [NCH-1:0]   held_q;
  logic [CNT_W-1:0] db_cnt_q [NCH];

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [CNT_W-1:0] rpt_cnt_q [NCH];
  logic [CNT_W-1:0] rpt_cnt_d [NCH];
  logic [NCH-1:0]   event_c;

  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   req_c, grant_c;

  // Two-flop synchronisers; reset value is the released level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_s1 <= '1;
      key_s2 <= '1;
      kb_s1  <= '0;
      kb_s2  <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      kb_s1  <= kb_hold;
      kb_s2  <= kb_s1;
    end
  end

  assign raw_c = ~key_s2 | kb_s2;

  // Debounce: held toggles after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      held_q <= '0;
      for (int i = 0; i < NCH; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (raw_c[i] == held_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          held_q[i]   <= ~held_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  assign held = held_q;

  // Channel FSM state and repeat counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]   <= ST_IDLE;
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]   <= state_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end

  // Channel FSM next state; release wins over any coincident repeat event.
  always_comb begin
    event_c = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i]   = state_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (held_q[i]) begin
            event_c[i]   = 1'b1;
            state_d[i]   = ST_DELAY;
            rpt_cnt_d[i] = '0;
          end
        end
        ST_DELAY: begin
          if (!held_q[i]) begin
            state_d[i]   = ST_IDLE;
            rpt_cnt_d[i] = '0;
          end else if (!repeat_en) begin
            rpt_cnt_d[i] = '0;
          end else if (rpt_cnt_q[i] == RD_LAST) begin
            event_c[i]   = 1'b1;
            state_d[i]   = ST_REPEAT;
            rpt_cnt_d[i] = '0;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (!held_q[i]) begin
            state_d[i]   = ST_IDLE;
            rpt_cnt_d[i] = '0;
          end else if (!repeat_en) begin
            state_d[i]   = ST_DELAY;
            rpt_cnt_d[i] = '0;
          end else if (rpt_cnt_q[i] == RR_LAST) begin
            event_c[i]   = 1'b1;
            rpt_cnt_d[i] = '0;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i]   = ST_IDLE;
          rpt_cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Fixed-priority grant over pending plus new events: up > down > left > right.
  always_comb begin
    req_c   = pending_q | event_c;
    grant_c = '0;
    if (req_c[1])      grant_c[1] = 1'b1;
    else if (req_c[2]) grant_c[2] = 1'b1;
    else if (req_c[3]) grant_c[3] = 1'b1;
    else if (req_c[0]) grant_c[0] = 1'b1;
    pending_d = req_c & ~grant_c;
  end

  // Pending bits and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_q <= '0;
      btn_up    <= 1'b0;
      btn_down  <= 1'b0;
      btn_left  <= 1'b0;
      btn_right <= 1'b0;
    end else begin
      pending_q <= pending_d;
      btn_up    <= grant_c[1];
      btn_down  <= grant_c[2];
      btn_left  <= grant_c[3];
      btn_right <= grant_c[0];
    end
  end

endmodule

// File: tb/tb_nav_input_conditioner.sv
// Directed bench for nav_input_conditioner with small timing parameters.
module tb_nav_input_conditioner;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] key_n;
  logic [3:0] kb_hold;
  logic       repeat_en;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [3:0] held;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int up_n = 0, down_n = 0, left_n = 0, right_n = 0;
  int multi_n = 0, consec_n = 0;
  logic p_up = 1'b0, p_down = 1'b0, p_left = 1'b0, p_right = 1'b0;

  nav_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(8),
    .CNT_W(25)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .key_n(key_n),
    .kb_hold(kb_hold),
    .repeat_en(repeat_en),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .held(held)
  );

  always #5 clk = ~clk;

  // Pulse counters and one-hot / single-cycle monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (btn_up)    up_n++;
    if (btn_down)  down_n++;
    if (btn_left)  left_n++;
    if (btn_right) right_n++;
    if ((int'(btn_up) + int'(btn_down) + int'(btn_left) + int'(btn_right)) > 1) multi_n++;
    if ((btn_up && p_up) || (btn_down && p_down) || (btn_left && p_left) || (btn_right && p_right))
      consec_n++;
    p_up = btn_up; p_down = btn_down; p_left = btn_left; p_right = btn_right;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] btns();
    return {28'd0, btn_left, btn_down, btn_up, btn_right};
  endfunction

  int t0, t1, r, base;

  initial begin
    resetn    = 1'b0;
    key_n     = 4'hF;
    kb_hold   = 4'h0;
    repeat_en = 1'b0;
    tick(3);
    check("reset_held", 32'(held), 32'h0);
    check("reset_btns", btns(), 32'h0);
    resetn = 1'b1;
    wait_to(10);

    // 1: single board press on up
    t0 = cyc; base = up_n;
    key_n[1] = 1'b0;
    wait_to(t0 + 5);  check("t1_held_pre", 32'(held[1]), 32'h0);
    wait_to(t0 + 6);  check("t1_held_rise", 32'(held[1]), 32'h1);
                      check("t1_no_early", 32'(btn_up), 32'h0);
    wait_to(t0 + 7);  check("t1_pulse", btns(), 32'h2);
    wait_to(t0 + 8);  check("t1_pulse_end", 32'(btn_up), 32'h0);
    wait_to(t0 + 45); check("t1_single", 32'(up_n - base), 32'h1);
    key_n[1] = 1'b1;
    wait_to(t0 + 65); check("t1_release", 32'(held), 32'h0);
                      check("t1_no_more", 32'(up_n - base), 32'h1);

    // 2: short keyboard glitch rejected, then a 5-cycle press accepted
    t0 = cyc; base = right_n;
    kb_hold[0] = 1'b1;
    tick(3);
    kb_hold[0] = 1'b0;
    wait_to(t0 + 6);  check("t2_glitch_held6", 32'(held[0]), 32'h0);
    wait_to(t0 + 15); check("t2_glitch_held", 32'(held[0]), 32'h0);
                      check("t2_glitch_btn", 32'(right_n - base), 32'h0);
    t1 = cyc;
    kb_hold[0] = 1'b1;
    tick(5);
    kb_hold[0] = 1'b0;
    wait_to(t1 + 6);  check("t2_press_held", 32'(held[0]), 32'h1);
    wait_to(t1 + 7);  check("t2_press_pulse", btns(), 32'h1);
    wait_to(t1 + 11); check("t2_press_release", 32'(held[0]), 32'h0);
    wait_to(t1 + 25); check("t2_one_pulse", 32'(right_n - base), 32'h1);

    // 3: hold-to-repeat on down
    repeat_en = 1'b1;
    t0 = cyc; base = down_n;
    key_n[2] = 1'b0;
    wait_to(t0 + 7);  check("t3_p0", 32'(btn_down), 32'h1);
    wait_to(t0 + 26); check("t3_gap", 32'(btn_down), 32'h0);
    wait_to(t0 + 27); check("t3_p1", 32'(btn_down), 32'h1);
    wait_to(t0 + 35); check("t3_p2", 32'(btn_down), 32'h1);
    wait_to(t0 + 43); check("t3_p3", 32'(btn_down), 32'h1);
    wait_to(t0 + 51); check("t3_p4", 32'(btn_down), 32'h1);
    wait_to(t0 + 59); check("t3_p5", 32'(btn_down), 32'h1);
    wait_to(t0 + 60);
    key_n[2] = 1'b1;
    wait_to(t0 + 66); check("t3_release", 32'(held[2]), 32'h0);
    wait_to(t0 + 90); check("t3_count", 32'(down_n - base), 32'h6);
    repeat_en = 1'b0;

    // 4: simultaneous left board press and up keyboard press
    t0 = cyc;
    key_n[3] = 1'b0;
    kb_hold[1] = 1'b1;
    wait_to(t0 + 7);  check("t4_first_up", btns(), 32'h2);
    wait_to(t0 + 8);  check("t4_then_left", btns(), 32'h8);
    wait_to(t0 + 9);  check("t4_quiet", btns(), 32'h0);
    key_n[3] = 1'b1;
    kb_hold[1] = 1'b0;
    wait_to(t0 + 25);

    // 5: key and keyboard on right, partial release keeps the channel held
    t0 = cyc; base = right_n;
    key_n[0] = 1'b0;
    kb_hold[0] = 1'b1;
    wait_to(t0 + 7);  check("t5_pulse", btns(), 32'h1);
    wait_to(t0 + 15);
    key_n[0] = 1'b1;
    wait_to(t0 + 35); check("t5_still_held", 32'(held[0]), 32'h1);
                      check("t5_one_pulse", 32'(right_n - base), 32'h1);
    kb_hold[0] = 1'b0;
    wait_to(t0 + 55); check("t5_released", 32'(held[0]), 32'h0);

    // 6: reset while up is held in DELAY, then a fresh press
    t0 = cyc; base = up_n;
    key_n[1] = 1'b0;
    wait_to(t0 + 7);  check("t6_first", 32'(btn_up), 32'h1);
    wait_to(t0 + 12);
    r = cyc;
    resetn = 1'b0;
    wait_to(r + 1);   check("t6_rst_btns", btns(), 32'h0);
                      check("t6_rst_held", 32'(held), 32'h0);
    wait_to(r + 2);
    resetn = 1'b1;
    wait_to(r + 8);   check("t6_no_early", 32'(btn_up), 32'h0);
                      check("t6_held_back", 32'(held[1]), 32'h1);
    wait_to(r + 9);   check("t6_fresh", 32'(btn_up), 32'h1);
    wait_to(r + 30);  check("t6_count", 32'(up_n - base), 32'h2);
    key_n[1] = 1'b1;
    wait_to(r + 45);

    check("one_hot_outputs", 32'(multi_n), 32'h0);
    check("single_cycle_outputs", 32'(consec_n), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
